// File: rtl/gate_truth_checker.sv
// Exhaustive stimulus and truth-table checker for a small combinational gate.
// Steps every input vector in ascending order, samples the gate after a settle window.
module gate_truth_checker #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   exp_table,
    output logic [N_IN-1:0]        vec_out,
    input  logic                   dut_y,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic                   fail_valid,
    output logic [N_IN-1:0]        first_fail_idx
);

    localparam int unsigned NVec = 1 << N_IN;
    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LastVec = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [NVec-1:0]   table_q, table_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [N_IN:0]     err_q, err_d;
    logic              fail_valid_q, fail_valid_d;
    logic [N_IN-1:0]   first_fail_q, first_fail_d;
    logic              pass_q, pass_d;
    logic              mismatch;

    assign mismatch = (dut_y != table_q[vec_q]);

    always_comb begin
        state_d      = state_q;
        table_d      = table_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    table_d      = exp_table;
                    vec_d        = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                    cnt_d        = CntInit;
                    state_d      = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        first_fail_d = vec_q;
                    end
                end
                if (vec_q == LastVec) begin
                    // Verdict uses the count including this final vector.
                    pass_d  = (err_d == '0);
                    state_d = StDone;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = CntInit;
                    state_d = StSettle;
                end
            end
            StDone: begin
                vec_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            table_q      <= '0;
            vec_q        <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            table_q      <= table_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
        end
    end

    assign vec_out        = vec_q;
    assign busy           = (state_q == StSettle) || (state_q == StCheck);
    assign done           = (state_q == StDone);
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_idx = first_fail_q;

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Self-checking stimulus stage for small combinational gates such as `nand_gate`. It sits directly upstream of the gate under test and drives every input combination in ascending binary order. After a settle window it consumes the gate's output and compares it against a caller-supplied expected truth table. It reports an error count, the first failing vector and a pass flag, so gate verification runs on-chip or in simulation without hand-written `$display` tables.

## Interface
- `N_IN`, default 2: number of gate inputs. Range 1..6.
- `SETTLE`, default 1: settle cycles per vector before sampling. Range ≥1.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: begin a run; sampled only in IDLE.
- `exp_table` input 2^N_IN: expected output, bit i = expected `dut_y` for vector i. For NAND, index {a,b} gives 4'b0111. Latched on start.
- `vec_out` output N_IN: drives the gate inputs; MSB→first gate input (`a`).
- `dut_y` input 1: gate output under test.
- `busy` output 1: high from the start-acceptance edge until done rises.
- `done` output 1: one-cycle pulse at end of run.
- `pass` output 1: 1 iff the last completed run had zero mismatches; held until the next start is accepted.
- `err_count` output N_IN+1: mismatches in the current or last run.
- `fail_valid` output 1: at least one mismatch recorded.
- `first_fail_idx` output N_IN: index of the first mismatching vector; valid when `fail_valid`.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- **Reset (async, rst_n=0):**
  - State → IDLE.
  - `vec_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `first_fail_idx`=0.
  - Latched table cleared.
  - Applies immediately, including mid-run; the run is abandoned with no done pulse.
- **IDLE, start=1:**
  - Latch `exp_table`; `vec_out`←0.
  - Clear `err_count`, `fail_valid`, `first_fail_idx` and `pass`.
  - Set `busy`=1, settle counter ← SETTLE-1, go to SETTLE.
- **IDLE, start=0:** hold. `start` is ignored in every other state; there is no restart while busy.
- **SETTLE:** if counter==0 go to CHECK, else decrement. `dut_y` is not sampled; glitches here never count.
- **CHECK (one cycle):** compare `dut_y` with latched bit[`vec_out`].
  - On mismatch: `err_count`+1. If `fail_valid`=0, set `fail_valid`=1 and `first_fail_idx`←`vec_out`.
  - If `vec_out`==2^N_IN-1: go to DONE.
  - Else: `vec_out`+1, counter←SETTLE-1, go to SETTLE.
- **DONE (one cycle):**
  - `done`=1, `busy`=0.
  - `pass`←(err_count==0), using the count including the final CHECK.
  - `vec_out`←0; go to IDLE.
- **Width and boundary rules:**
  - `err_count` never saturates; maximum is 2^N_IN, which fits N_IN+1 bits.
  - `vec_out` never wraps within a run.
  - Result outputs hold after DONE until the next accepted start or reset.

## Timing
- Start accepted on rising edge E0. `vec_out`=0 and `busy`=1 are visible after E0.
- Each vector is held for SETTLE+1 cycles; `dut_y` is sampled at that vector's last edge (the CHECK edge).
- `done` is high for exactly the cycle after edge E0 + 2^N_IN·(SETTLE+1).
  - N_IN=2, SETTLE=1: `done` rises 8 edges after E0.
- `busy` falls in the same edge `done` rises. Next start is accepted no earlier than the cycle after `done`.
- The gate under test must settle within SETTLE cycles; gate path delay is assumed < 1 clock per settle cycle.

## Test plan
- **Correct NAND.** dut_y=~&vec_out, exp_table=4'b0111, N_IN=2, SETTLE=1, pulse start. Required: vec_out steps 0,1,2,3 each for 2 cycles; done 8 edges after start; pass=1, err_count=0, fail_valid=0.
- **Stuck-at-0 gate.** dut_y=0, exp 4'b0111. Required: err_count=3, fail_valid=1, first_fail_idx=0, pass=0.
- **Wrong function (AND wired in place of NAND).** exp 4'b0111. Required: err_count=4, first_fail_idx=0, pass=0. Then a second run with a correct NAND: counters cleared at start, pass=1.
- **Reset and ignored start.**
  - Assert rst_n=0 mid-run during vec_out=2. Required: all outputs go to reset values immediately, no done pulse.
  - After release, a start pulse while busy is ignored: the run completes at the original 8-cycle timing.
- **Settle filtering, SETTLE=3.** dut_y glitches to the wrong value during settle cycles but is correct at CHECK. Required: err_count=0, pass=1, done 16 edges after start.
- **N_IN=1 inverter.** exp 2'b01, correct inverter. Required: pass=1, done 4 edges after start with SETTLE=1.
